inference_sequencer: RTL and testbench

Control FSM that sequences one digit-recognition pass per trigger, or runs continuously. The pass is: camera-config wait, frame settling, ROI capture from the framebuffer, then the LeNet run and result publication. It lives in the Clk (50 MHz) domain, takes VGA vsync and retrieve-done from the VGA_CLK domain through synchronizers, and drives the retrieve hold and net start signals. It adds a per-phase watchdog and a state code for the HEX display.

---
 rtl/inference_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_inference_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inference_sequencer.sv
`timescale 1ns/1ps
// inference_sequencer
// Sequences one digit-recognition pass per trigger, or passes back to back
// while run is high. A pass waits for the camera config, lets the frame settle
// for SETTLE_FRAMES vsync falls, releases Retrieve_Data for ROI capture, then
// runs LeNet and publishes the class. CAPTURE and INFER share a watchdog.
// Optional macro VOTE_FILTER_EN: publish a digit only after VOTE_DEPTH
// consecutive equal valid inferences that differ from the current result.
// Ports:
//   Clk, Reset                 50 MHz clock, synchronous active-high reset
//   config_done                camera register load complete
//   trigger / run / debug_req  single pass (rising edge) / continuous / debug
//   vsync_async                VGA vsync (VGA_CLK domain)
//   retrieve_done_async        ROI capture complete (VGA_CLK domain)
//   net_done, inference        LeNet handshake and class output
//   hold_retrieve_n, net_start retrieve hold (active low) and net start
//   result, result_valid       published digit and one-cycle publish pulse
//   busy, err_timeout, err_range, state_code   status for the HEX display
module inference_sequencer #(
  parameter int SETTLE_FRAMES  = 60,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int VOTE_DEPTH     = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       config_done,
  input  logic       trigger,
  input  logic       run,
  input  logic       debug_req,
  input  logic       vsync_async,
  input  logic       retrieve_done_async,
  input  logic       net_done,
  input  logic [3:0] inference,
  output logic       hold_retrieve_n,
  output logic       net_start,
  output logic [3:0] result,
  output logic       result_valid,
  output logic       busy,
  output logic       err_timeout,
  output logic       err_range,
  output logic [3:0] state_code
);

  localparam int              WD_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      FR_LAST = 8'(SETTLE_FRAMES - 1);

  typedef enum logic [3:0] {
    CONFIG_WAIT = 4'd0,
    IDLE        = 4'd1,
    FRAME_WAIT  = 4'd2,
    CAPTURE     = 4'd3,
    INFER       = 4'd4,
    PUBLISH     = 4'd5,
    DEBUG       = 4'd6
  } state_t;

  state_t          r_state, w_next;
  logic [2:0]      r_vs_sync, r_rd_sync;  // [1] is the synchronized level, [2] its previous value
  logic            r_trig_d;
  logic [7:0]      r_frame;
  logic [WD_W-1:0] r_wdog;

  logic w_vs_fall, w_rd_rise, w_trig_rise, w_wd_exp;
  logic w_start, w_clr_frame, w_inc_frame, w_clr_wdog, w_set_to, w_accept;
  logic w_inf_ok, w_pub;

  assign w_vs_fall   = r_vs_sync[2] & ~r_vs_sync[1];
  assign w_rd_rise   = ~r_rd_sync[2] & r_rd_sync[1];
  assign w_trig_rise = trigger & ~r_trig_d;
  assign w_wd_exp    = (r_wdog == WD_LAST);
  assign w_inf_ok    = (inference <= 4'd9);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_vs_sync <= '0;
      r_rd_sync <= '0;
      r_trig_d  <= 1'b0;
    end else begin
      r_vs_sync <= {r_vs_sync[1:0], vsync_async};
      r_rd_sync <= {r_rd_sync[1:0], retrieve_done_async};
      r_trig_d  <= trigger;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_clr_frame = 1'b0;
    w_inc_frame = 1'b0;
    w_clr_wdog  = 1'b0;
    w_set_to    = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      CONFIG_WAIT: if (config_done) w_next = IDLE;
      IDLE: begin
        if (debug_req) w_next = DEBUG;
        else if (w_trig_rise || run) begin
          w_next      = FRAME_WAIT;
          w_start     = 1'b1;
          w_clr_frame = 1'b1;
        end
      end
      FRAME_WAIT: begin
        if (w_vs_fall) begin
          if (r_frame == FR_LAST) begin
            w_next     = CAPTURE;
            w_clr_wdog = 1'b1;
          end else begin
            w_inc_frame = 1'b1;
          end
        end
      end
      CAPTURE: begin
        // completion beats an expiring watchdog in the same cycle
        if (w_rd_rise) begin
          w_next     = INFER;
          w_clr_wdog = 1'b1;
        end else if (w_wd_exp) begin
          w_next   = IDLE;
          w_set_to = 1'b1;
        end
      end
      INFER: begin
        if (net_done) begin
          w_next   = PUBLISH;
          w_accept = 1'b1;
        end else if (w_wd_exp) begin
          w_next   = IDLE;
          w_set_to = 1'b1;
        end
      end
      PUBLISH: begin
        // one inference per frame: leave only on a vsync fall
        if (w_vs_fall) begin
          if (run) begin
            w_next      = FRAME_WAIT;
            w_clr_frame = 1'b1;
          end else begin
            w_next = IDLE;
          end
        end
      end
      DEBUG:   if (!debug_req) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= CONFIG_WAIT;
      r_frame     <= '0;
      r_wdog      <= '0;
      err_timeout <= 1'b0;
      err_range   <= 1'b0;
      result      <= '0;
      result_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_clr_frame)                           r_frame <= '0;
      else if (w_inc_frame && r_frame != 8'hFF)  r_frame <= r_frame + 8'd1;
      if (w_clr_wdog)                            r_wdog <= '0;
      else if ((r_state == CAPTURE || r_state == INFER) && !w_wd_exp)
                                                 r_wdog <= r_wdog + 1'b1;
      if (w_start)       err_timeout <= 1'b0;
      else if (w_set_to) err_timeout <= 1'b1;
      err_range    <= w_accept & ~w_inf_ok;
      result_valid <= w_pub;
      if (w_pub) result <= inference;
    end
  end

`ifdef VOTE_FILTER_EN
  // The inference being accepted is the newest vote; r_hist keeps the
  // VOTE_DEPTH-1 older ones, r_hist[0] most recent.
  logic [VOTE_DEPTH-2:0][3:0] r_hist;
  logic [3:0]                 r_fill;
  logic                       w_hist_match;

  always_comb begin
    w_hist_match = (r_fill >= 4'(VOTE_DEPTH - 1));
    for (int i = 0; i < VOTE_DEPTH - 1; i++)
      if (r_hist[i] != inference) w_hist_match = 1'b0;
  end

  assign w_pub = w_accept & w_inf_ok & w_hist_match & (inference != result);

  always_ff @(posedge Clk) begin
    if (Reset || w_start) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (w_accept && w_inf_ok) begin
      for (int i = VOTE_DEPTH - 2; i > 0; i--) r_hist[i] <= r_hist[i-1];
      r_hist[0] <= inference;
      if (r_fill < 4'(VOTE_DEPTH - 1)) r_fill <= r_fill + 4'd1;
    end
  end
`else
  assign w_pub = w_accept & w_inf_ok;
`endif

  assign hold_retrieve_n = ~(r_state == CAPTURE || r_state == DEBUG);
  assign net_start       = (r_state == INFER);
  assign busy            = (r_state == FRAME_WAIT) || (r_state == CAPTURE) ||
                           (r_state == INFER)      || (r_state == PUBLISH);
  assign state_code      = r_state;

endmodule

// File: tb/tb_inference_sequencer.sv
`timescale 1ns/1ps
module tb_inference_sequencer;
  localparam int VD = 3;

  logic       Clk = 1'b0;
  logic       Reset, config_done, trigger, run, debug_req;
  logic       vsync_async, retrieve_done_async, net_done;
  logic [3:0] inference;
  logic       hold_retrieve_n, net_start, result_valid, busy, err_timeout, err_range;
  logic [3:0] result, state_code;

  int         total = 0;
  int         bad = 0;
  int         pulses = 0;
  logic [3:0] exp_q[$];
  logic [3:0] m_result = 4'd0;
  logic [3:0] m_hist[$];

  inference_sequencer #(.SETTLE_FRAMES(3), .TIMEOUT_CYCLES(50), .VOTE_DEPTH(VD)) dut (
    .Clk(Clk), .Reset(Reset), .config_done(config_done), .trigger(trigger), .run(run),
    .debug_req(debug_req), .vsync_async(vsync_async), .retrieve_done_async(retrieve_done_async),
    .net_done(net_done), .inference(inference), .hold_retrieve_n(hold_retrieve_n),
    .net_start(net_start), .result(result), .result_valid(result_valid), .busy(busy),
    .err_timeout(err_timeout), .err_range(err_range), .state_code(state_code));

  always #10 Clk = ~Clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout state=%0d", state_code);
    $fatal(1, "simulation time limit");
  end

  // scoreboard consumer: every publish pulse must match the oldest expectation
  always @(negedge Clk) begin
    logic [3:0] e;
    if (Reset === 1'b0 && result_valid === 1'b1) begin
      pulses++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_publish got=%0d want=none", result);
      end else begin
        e = exp_q.pop_front();
        if (result !== e) begin
          bad++;
          $display("FAIL publish_value got=%0d want=%0d", result, e);
        end
      end
    end
  end

  // reference model of what a net_done with this class should publish
  task automatic expect_inference(input logic [3:0] inf);
    if (inf <= 4'd9) begin
`ifdef VOTE_FILTER_EN
      bit eq;
      m_hist.push_back(inf);
      if (m_hist.size() > VD) void'(m_hist.pop_front());
      eq = (m_hist.size() == VD);
      foreach (m_hist[i]) if (m_hist[i] != inf) eq = 0;
      if (eq && inf != m_result) begin
        exp_q.push_back(inf);
        m_result = inf;
      end
`else
      exp_q.push_back(inf);
      m_result = inf;
`endif
    end
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic wait_state(input logic [3:0] s, input string nm);
    int n = 0;
    while (state_code !== s && n < 1000) begin @(negedge Clk); n++; end
    if (state_code !== s) begin
      total++; bad++;
      $display("FAIL wait_%s got=%0d want=%0d", nm, state_code, s);
    end
  endtask

  task automatic vs_pulse();
    vsync_async = 1'b1; repeat (4) tick();
    vsync_async = 1'b0; repeat (4) tick();
  endtask

  task automatic start_trigger();
    m_hist.delete();
    trigger = 1'b1; tick(); trigger = 1'b0;
  endtask

  // two settle frames, then the third fall; returns on the first CAPTURE cycle
  task automatic frames_to_capture();
    repeat (2) vs_pulse();
    vsync_async = 1'b1; repeat (4) tick(); vsync_async = 1'b0;
    wait_state(4'd3, "capture");
  endtask

  // returns on the first INFER cycle
  task automatic capture_to_infer();
    retrieve_done_async = 1'b1;
    wait_state(4'd4, "infer");
    retrieve_done_async = 1'b0;
  endtask

  task automatic net_done_pulse(input logic [3:0] inf);
    expect_inference(inf);
    inference = inf; net_done = 1'b1; tick(); net_done = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; config_done = 1'b0; trigger = 1'b0; run = 1'b0; debug_req = 1'b0;
    vsync_async = 1'b0; retrieve_done_async = 1'b0; net_done = 1'b0; inference = 4'd0;
    repeat (3) tick();
    @(negedge Clk);
    total += 8;
    if (state_code !== 4'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", state_code); end
    if (hold_retrieve_n !== 1'b1) begin bad++; $display("FAIL rst_hold got=%b want=1", hold_retrieve_n); end
    if (net_start !== 1'b0) begin bad++; $display("FAIL rst_net_start got=%b want=0", net_start); end
    if (result !== 4'd0) begin bad++; $display("FAIL rst_result got=%0d want=0", result); end
    if (result_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", result_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    if (err_timeout !== 1'b0) begin bad++; $display("FAIL rst_err_to got=%b want=0", err_timeout); end
    if (err_range !== 1'b0) begin bad++; $display("FAIL rst_err_rng got=%b want=0", err_range); end
    Reset = 1'b0;
    repeat (6) tick();
    total++;
    if (state_code !== 4'd0) begin bad++; $display("FAIL cfg_wait got=%0d want=0", state_code); end
    config_done = 1'b1; tick();
    total++;
    if (state_code !== 4'd1) begin bad++; $display("FAIL cfg_idle got=%0d want=1", state_code); end
  endtask

  task automatic test_single_pass();
    int p0 = pulses;
    int want_p;
    start_trigger();
    total += 2;
    if (state_code !== 4'd2) begin bad++; $display("FAIL sp_frame_wait got=%0d want=2", state_code); end
    if (busy !== 1'b1) begin bad++; $display("FAIL sp_busy got=%b want=1", busy); end
    frames_to_capture();
    total += 2;
    if (hold_retrieve_n !== 1'b0) begin bad++; $display("FAIL sp_hold_cap got=%b want=0", hold_retrieve_n); end
    if (net_start !== 1'b0) begin bad++; $display("FAIL sp_ns_cap got=%b want=0", net_start); end
    repeat (20) tick();
    capture_to_infer();
    repeat (5) tick();
    total += 2;
    if (hold_retrieve_n !== 1'b1) begin bad++; $display("FAIL sp_hold_inf got=%b want=1", hold_retrieve_n); end
    if (net_start !== 1'b1) begin bad++; $display("FAIL sp_ns_inf got=%b want=1", net_start); end
    net_done_pulse(4'd7);
    total += 2;
    if (net_start !== 1'b0) begin bad++; $display("FAIL sp_ns_drop got=%b want=0", net_start); end
    if (state_code !== 4'd5) begin bad++; $display("FAIL sp_publish got=%0d want=5", state_code); end
    vs_pulse();
    wait_state(4'd1, "sp_idle");
`ifdef VOTE_FILTER_EN
    want_p = 0;
`else
    want_p = 1;
`endif
    total += 2;
    if (result !== m_result) begin bad++; $display("FAIL sp_result got=%0d want=%0d", result, m_result); end
    if (pulses - p0 != want_p) begin bad++; $display("FAIL sp_pulses got=%0d want=%0d", pulses - p0, want_p); end
  endtask

  task automatic test_run_vote();
    int p0 = pulses;
    int want_p;
    m_hist.delete();
    run = 1'b1; tick();
    for (int k = 0; k < 3; k++) begin
      wait_state(4'd2, "rv_frame");
      frames_to_capture();
      capture_to_infer();
      net_done_pulse(4'd4);
      if (k == 2) run = 1'b0;
      vs_pulse();
    end
    wait_state(4'd1, "rv_idle");
`ifdef VOTE_FILTER_EN
    want_p = 1;
`else
    want_p = 3;
`endif
    total += 2;
    if (pulses - p0 != want_p) begin bad++; $display("FAIL rv_pulses got=%0d want=%0d", pulses - p0, want_p); end
    if (result !== 4'd4) begin bad++; $display("FAIL rv_result got=%0d want=4", result); end
  endtask

  task automatic test_timeout();
    int n = 0;
    start_trigger();
    frames_to_capture();
    while (state_code === 4'd3 && n < 200) begin @(negedge Clk); n++; end
    total += 4;
    if (n != 50) begin bad++; $display("FAIL to_cycles got=%0d want=50", n); end
    if (state_code !== 4'd1) begin bad++; $display("FAIL to_state got=%0d want=1", state_code); end
    if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_flag got=%b want=1", err_timeout); end
    if (hold_retrieve_n !== 1'b1) begin bad++; $display("FAIL to_hold got=%b want=1", hold_retrieve_n); end
    start_trigger();
    total++;
    if (err_timeout !== 1'b0) begin bad++; $display("FAIL to_clear got=%b want=0", err_timeout); end
  endtask

  // continues the pass started at the end of test_timeout
  task automatic test_range_timeout();
    logic [3:0] r0 = m_result;
    frames_to_capture();
    capture_to_infer();
    // net_done lands on the last watchdog cycle of INFER
    repeat (49) @(posedge Clk);
    #1;
    net_done_pulse(4'd12);
    total += 4;
    if (state_code !== 4'd5) begin bad++; $display("FAIL rg_state got=%0d want=5", state_code); end
    if (err_range !== 1'b1) begin bad++; $display("FAIL rg_pulse got=%b want=1", err_range); end
    if (err_timeout !== 1'b0) begin bad++; $display("FAIL rg_no_to got=%b want=0", err_timeout); end
    if (result !== r0) begin bad++; $display("FAIL rg_result got=%0d want=%0d", result, r0); end
    tick();
    total++;
    if (err_range !== 1'b0) begin bad++; $display("FAIL rg_one_cycle got=%b want=0", err_range); end
    vs_pulse();
    wait_state(4'd1, "rg_idle");
  endtask

  task automatic test_debug();
    debug_req = 1'b1; trigger = 1'b1; tick();
    total += 4;
    if (state_code !== 4'd6) begin bad++; $display("FAIL dbg_state got=%0d want=6", state_code); end
    if (hold_retrieve_n !== 1'b0) begin bad++; $display("FAIL dbg_hold got=%b want=0", hold_retrieve_n); end
    if (net_start !== 1'b0) begin bad++; $display("FAIL dbg_ns got=%b want=0", net_start); end
    if (busy !== 1'b0) begin bad++; $display("FAIL dbg_busy got=%b want=0", busy); end
    trigger = 1'b0; tick();
    total++;
    if (state_code !== 4'd6) begin bad++; $display("FAIL dbg_hold_state got=%0d want=6", state_code); end
    debug_req = 1'b0; tick();
    total++;
    if (state_code !== 4'd1) begin bad++; $display("FAIL dbg_exit got=%0d want=1", state_code); end
  endtask

  task automatic test_reset_mid_infer();
    start_trigger();
    frames_to_capture();
    capture_to_infer();
    tick();
    total++;
    if (net_start !== 1'b1) begin bad++; $display("FAIL rmi_ns_pre got=%b want=1", net_start); end
    Reset = 1'b1; tick();
    total += 4;
    if (net_start !== 1'b0) begin bad++; $display("FAIL rmi_ns got=%b want=0", net_start); end
    if (state_code !== 4'd0) begin bad++; $display("FAIL rmi_state got=%0d want=0", state_code); end
    if (result !== 4'd0) begin bad++; $display("FAIL rmi_result got=%0d want=0", result); end
    if (hold_retrieve_n !== 1'b1) begin bad++; $display("FAIL rmi_hold got=%b want=1", hold_retrieve_n); end
    Reset = 1'b0; m_result = 4'd0; m_hist.delete();
    tick();
    total++;
    if (state_code !== 4'd1) begin bad++; $display("FAIL rmi_idle got=%0d want=1", state_code); end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_run_vote();
    test_timeout();
    test_range_timeout();
    test_debug();
    test_reset_mid_infer();
    repeat (4) tick();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL missing_publish got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
